// File: rtl/pad_ctrl_if.sv
// pad_ctrl_if: APB slave bus bundle for the pad controller
interface pad_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/pad_ctrl.sv
// pad_ctrl: APB-programmed padring control with synchronised input readback and rise interrupts
module pad_ctrl #(
    parameter int NUM_PADS = 32
) (
    input  logic                  pclk,
    input  logic                  presetn,
    pad_ctrl_if.slave             apb,
    output logic [NUM_PADS-1:0]   pad_din,
    input  logic [NUM_PADS-1:0]   pad_dout,
    output logic [4*NUM_PADS-1:0] pad_ctl,
    output logic                  irq
);
    localparam int N = NUM_PADS;
    logic [N-1:0] dout_r, oe_r, ie_r, pu_r, pd_r, inten_r, intstat_r;
    logic [N-1:0] sync1, sync2, sync3, din, rise, wd, rd;
    logic [N-1:0] regs [8];
    logic [2:0]   idx;
    logic         access, valid, wr;
    assign access = apb.psel & apb.penable;
    assign valid  = apb.paddr[7:5] == 3'd0 && apb.paddr[1:0] == 2'd0;
    assign idx    = apb.paddr[4:2];
    assign wr     = access & apb.pwrite & valid;
    assign wd     = apb.pwdata[N-1:0];
    // a pad disabled by IE reads 0 and cannot produce a rise
    assign din  = sync2 & ie_r;
    assign rise = din & ~sync3;
    assign regs = '{dout_r, oe_r, ie_r, pu_r, pd_r, din, inten_r, intstat_r};
    assign rd   = regs[idx];
    assign apb.prdata  = (access & valid) ? 32'(rd) : 32'd0;
    assign apb.pslverr = access & ~valid;
    assign apb.pready  = 1'b1;
    assign pad_din = dout_r;
    assign irq     = |(intstat_r & inten_r);
    always_comb begin
        pad_ctl = '0;
        for (int i = 0; i < N; i++)
            pad_ctl[4*i +: 4] = {pd_r[i] & ~pu_r[i], pu_r[i], ie_r[i], oe_r[i]};
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            dout_r    <= '0;
            oe_r      <= '0;
            ie_r      <= '0;
            pu_r      <= '0;
            pd_r      <= '0;
            inten_r   <= '0;
            intstat_r <= '0;
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
        end else begin
            dout_r    <= (wr && idx == 3'd0) ? wd : dout_r;
            oe_r      <= (wr && idx == 3'd1) ? wd : oe_r;
            ie_r      <= (wr && idx == 3'd2) ? wd : ie_r;
            pu_r      <= (wr && idx == 3'd3) ? wd : pu_r;
            pd_r      <= (wr && idx == 3'd4) ? wd : pd_r;
            inten_r   <= (wr && idx == 3'd6) ? wd : inten_r;
            // new rise is OR-ed after the W1C mask so a same-edge set wins
            intstat_r <= (intstat_r & ~((wr && idx == 3'd7) ? wd : '0)) | (rise & inten_r);
            sync1     <= pad_dout;
            sync2     <= sync1;
            sync3     <= din;
        end
    end
endmodule
